// File: rtl/plc_timer_pkg.sv
// rtl/plc_timer_pkg.sv - mode encodings and channel state type for the PLC timer bank
package plc_timer_pkg;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_MAN = 2'b01;
  localparam logic [1:0] MODE_TON = 2'b10;
  localparam logic [1:0] MODE_TOF = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_TIMING = 2'b01,
    ST_ON     = 2'b10
  } ch_state_t;

endpackage

// File: rtl/plc_timer_ch.sv
// rtl/plc_timer_ch.sv - one timer channel: FSM, elapsed counter, preset register, mode-change detect
module plc_timer_ch #(
  parameter int CNT_W          = 16,
  parameter int DEFAULT_PRESET = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_tick,
  input  logic             i_estop,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic             i_we,
  input  logic [CNT_W-1:0] i_preset,
  output logic [CNT_W-1:0] o_elapsed,
  output logic             o_out,
  output logic             o_busy,
  output logic             o_done
);
  import plc_timer_pkg::*;

  ch_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_elapsed, w_elapsed_nxt;
  logic [CNT_W-1:0] r_preset;
  logic [1:0]       r_mode_prev, w_mode_prev_nxt;
  logic             r_out, w_out_nxt;
  logic             r_done, w_done_nxt;
  logic             w_mode_chg;
  logic [CNT_W:0]   w_inc;
  logic             w_expire;
  logic             w_preset_zero;

  assign w_mode_chg    = (i_mode != r_mode_prev);
  assign w_inc         = {1'b0, r_elapsed} + {{CNT_W{1'b0}}, 1'b1};
  // Compared with >= so a preset lowered below elapsed still expires on the next tick.
  assign w_expire      = (w_inc >= {1'b0, r_preset});
  assign w_preset_zero = (r_preset == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_elapsed   <= '0;
      r_preset    <= CNT_W'(DEFAULT_PRESET);
      r_mode_prev <= MODE_OFF;
      r_out       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_elapsed   <= w_elapsed_nxt;
      r_mode_prev <= w_mode_prev_nxt;
      r_out       <= w_out_nxt;
      r_done      <= w_done_nxt;
      if (i_we) r_preset <= i_preset;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_elapsed_nxt   = r_elapsed;
    w_mode_prev_nxt = r_mode_prev;
    w_done_nxt      = 1'b0;
    if (i_estop) begin
      w_state_nxt     = ST_IDLE;
      w_elapsed_nxt   = '0;
      w_mode_prev_nxt = i_mode;
    end else if (!i_en) begin
      w_state_nxt   = r_state;
      w_elapsed_nxt = r_elapsed;
    end else if (w_mode_chg) begin
      w_state_nxt     = ST_IDLE;
      w_elapsed_nxt   = '0;
      w_mode_prev_nxt = i_mode;
    end else begin
      case (i_mode)
        MODE_TON: begin
          if (!i_start) begin
            w_state_nxt   = ST_IDLE;
            w_elapsed_nxt = '0;
          end else begin
            case (r_state)
              ST_IDLE: begin
                w_elapsed_nxt = '0;
                if (w_preset_zero) begin
                  w_state_nxt = ST_ON;
                  w_done_nxt  = 1'b1;
                end else begin
                  w_state_nxt = ST_TIMING;
                end
              end
              ST_TIMING: begin
                if (i_tick) begin
                  if (w_expire) begin
                    w_state_nxt   = ST_ON;
                    w_elapsed_nxt = r_preset;
                    w_done_nxt    = 1'b1;
                  end else begin
                    w_elapsed_nxt = w_inc[CNT_W-1:0];
                  end
                end
              end
              default: w_state_nxt = ST_ON;
            endcase
          end
        end
        MODE_TOF: begin
          case (r_state)
            ST_IDLE: begin
              if (i_start) begin
                w_state_nxt   = ST_ON;
                w_elapsed_nxt = '0;
              end
            end
            ST_ON: begin
              if (!i_start) begin
                w_elapsed_nxt = '0;
                if (w_preset_zero) begin
                  w_state_nxt = ST_IDLE;
                  w_done_nxt  = 1'b1;
                end else begin
                  w_state_nxt = ST_TIMING;
                end
              end
            end
            default: begin
              if (i_start) begin
                w_state_nxt   = ST_ON;
                w_elapsed_nxt = '0;
              end else if (i_tick) begin
                if (w_expire) begin
                  w_state_nxt   = ST_IDLE;
                  w_elapsed_nxt = r_preset;
                  w_done_nxt    = 1'b1;
                end else begin
                  w_elapsed_nxt = w_inc[CNT_W-1:0];
                end
              end
            end
          endcase
        end
        default: begin
          w_state_nxt   = ST_IDLE;
          w_elapsed_nxt = '0;
        end
      endcase
    end
  end

  // Output is registered from the next state so out and done_pulse rise on the same edge.
  always_comb begin
    w_out_nxt = 1'b0;
    if (i_estop || w_mode_chg) begin
      w_out_nxt = 1'b0;
    end else if (!i_en) begin
      w_out_nxt = r_out;
    end else begin
      case (i_mode)
        MODE_MAN: w_out_nxt = i_start;
        MODE_TON: w_out_nxt = (w_state_nxt == ST_ON);
        MODE_TOF: w_out_nxt = (w_state_nxt == ST_ON) || (w_state_nxt == ST_TIMING);
        default:  w_out_nxt = 1'b0;
      endcase
    end
  end

  assign o_elapsed = r_elapsed;
  assign o_out     = r_out;
  assign o_busy    = (r_state == ST_TIMING);
  assign o_done    = r_done;

endmodule

// File: rtl/plc_timer_bank.sv
// rtl/plc_timer_bank.sv - multi-channel PLC timer bank with shared prescaler, preset writes and readback
module plc_timer_bank #(
  parameter int NUM_CH         = 4,
  parameter int CNT_W          = 16,
  parameter int PRESCALE       = 1,
  parameter int DEFAULT_PRESET = 20,
  parameter int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                estop,
  input  logic [NUM_CH-1:0]   start,
  input  logic [2*NUM_CH-1:0] mode,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_preset,
  input  logic [CH_W-1:0]     rd_ch,
  output logic [CNT_W-1:0]    rd_elapsed,
  output logic [NUM_CH-1:0]   out,
  output logic [NUM_CH-1:0]   busy,
  output logic [NUM_CH-1:0]   done_pulse
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  r_prescale;
  logic             w_tick;
  logic [CNT_W-1:0] w_elapsed [NUM_CH];
  logic [CNT_W-1:0] w_rd_sel;
  logic [CNT_W-1:0] r_rd_elapsed;

  assign w_tick = (r_prescale == PS_W'(PRESCALE - 1));

  // The prescaler keeps running through estop so tick phase is preserved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prescale <= '0;
    end else if (en) begin
      r_prescale <= w_tick ? '0 : r_prescale + PS_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic w_we;
    assign w_we = cfg_we && (cfg_ch == CH_W'(i));

    plc_timer_ch #(
      .CNT_W          (CNT_W),
      .DEFAULT_PRESET (DEFAULT_PRESET)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .i_en      (en),
      .i_tick    (w_tick),
      .i_estop   (estop),
      .i_start   (start[i]),
      .i_mode    (mode[2*i+1:2*i]),
      .i_we      (w_we),
      .i_preset  (cfg_preset),
      .o_elapsed (w_elapsed[i]),
      .o_out     (out[i]),
      .o_busy    (busy[i]),
      .o_done    (done_pulse[i])
    );
  end

  always_comb begin
    w_rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch == CH_W'(i)) w_rd_sel = w_elapsed[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_elapsed <= '0;
    end else begin
      r_rd_elapsed <= w_rd_sel;
    end
  end

  assign rd_elapsed = r_rd_elapsed;

endmodule
